// File: rtl/letc_rst_pkg.sv
// Shared types and helpers for the LETC FPGA reset controller.
// Holds the controller state encoding and reset-cause bit positions.
package letc_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_state_e;

    // Bit positions in the sticky cause vector; source i sits at CAUSE_SRC0+i.
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_SRC0 = 1;

    // Software-request cause bit sits just above the last source bit.
    function automatic int cause_sw_bit(input int num_src);
        return num_src + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/letc_rst_debounce.sv
// Synchroniser plus release debouncer for one async active-low reset source.
// Assertion passes straight through; release needs a run of clean samples.
module letc_rst_debounce
    import letc_rst_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic src_rst_n_i,
    output logic asserted_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   released_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Multi-flop synchroniser; resets to the asserted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_rst_n_i};
        end
    end

    // Count consecutive high samples; any low sample restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            released_q <= 1'b0;
        end else if (!synced) begin
            cnt_q      <= '0;
            released_q <= 1'b0;
        end else if (!released_q) begin
            if (cnt_q == DEB_LAST) begin
                cnt_q      <= '0;
                released_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // A low synced sample counts as asserted without waiting for the counter.
    assign asserted_o = !synced || !released_q;

endmodule

// File: rtl/letc_fpga_rst_ctrl.sv
// Board-level reset controller: debounced sources, hold time, staged release.
// Optional run heartbeat on heartbeat_o when LETC_RST_HEARTBEAT_EN is defined.
module letc_fpga_rst_ctrl
    import letc_rst_pkg::*;
#(
    parameter int NUM_SRC         = 2,
    parameter int NUM_DOM         = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGE_GAP       = 4,
    parameter int HEARTBEAT_DIV   = 2**24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src_rst_n_i,
    input  logic               sw_rst_req_i,
    output logic [NUM_DOM-1:0] dom_rst_n_o,
    output logic               all_released_o,
    output logic [NUM_SRC+1:0] rst_cause_o,
    output logic               heartbeat_o
);

    localparam int CNT_W   = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STAGE_GAP) + 1);
    localparam int CAUSE_W = NUM_SRC + 2;
    localparam int CAUSE_SW = cause_sw_bit(NUM_SRC);

    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [NUM_DOM-1:0] DOM_FIRST = NUM_DOM'(1);
    localparam logic [CAUSE_W-1:0] CAUSE_RST = CAUSE_W'(1) << CAUSE_POR;

    if (NUM_SRC < 1) begin : g_bad_src
        $error("letc_fpga_rst_ctrl: NUM_SRC must be >= 1");
    end
    if (NUM_DOM < 1) begin : g_bad_dom
        $error("letc_fpga_rst_ctrl: NUM_DOM must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("letc_fpga_rst_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("letc_fpga_rst_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("letc_fpga_rst_ctrl: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_gap
        $error("letc_fpga_rst_ctrl: STAGE_GAP must be >= 1");
    end
    if (HEARTBEAT_DIV < 1) begin : g_bad_hb
        $error("letc_fpga_rst_ctrl: HEARTBEAT_DIV must be >= 1");
    end

    logic [NUM_SRC-1:0] src_act;
    logic               any_rst;
    logic [CAUSE_W-1:0] cause_vec;

    rst_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DOM-1:0] dom_q, dom_d;
    logic               rel_q, rel_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        letc_rst_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .src_rst_n_i (src_rst_n_i[i]),
            .asserted_o  (src_act[i])
        );
    end

    assign any_rst = (|src_act) || sw_rst_req_i;

    // Snapshot of which requesters are active this cycle.
    always_comb begin
        cause_vec = '0;
        cause_vec[CAUSE_SW] = sw_rst_req_i;
        for (int i = 0; i < NUM_SRC; i++) begin
            cause_vec[CAUSE_SRC0 + i] = src_act[i];
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            dom_q   <= '0;
            rel_q   <= 1'b0;
            cause_q <= CAUSE_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            rel_q   <= rel_d;
            cause_q <= cause_d;
        end
    end

    // Sequencing: hold, then release domains one by one, lowest index first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        rel_d   = 1'b0;
        cause_d = cause_q;
        unique case (state_q)
            ASSERT: begin
                cnt_d = '0;
                dom_d = '0;
                if (!any_rst) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    dom_d = DOM_FIRST;
                    if (NUM_DOM == 1) begin
                        state_d = RUN;
                        rel_d   = 1'b1;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    dom_d = (dom_q << 1) | DOM_FIRST;
                    if (&dom_d) begin
                        state_d = RUN;
                        rel_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                rel_d = 1'b1;
            end
        endcase
        // A new reset request overrides any progress and records its cause.
        if (state_q != ASSERT && any_rst) begin
            state_d = ASSERT;
            cnt_d   = '0;
            dom_d   = '0;
            rel_d   = 1'b0;
            cause_d = cause_vec;
        end
    end

    assign dom_rst_n_o    = dom_q;
    assign all_released_o = rel_q;
    assign rst_cause_o    = cause_q;

`ifdef LETC_RST_HEARTBEAT_EN
    localparam int HB_W = $clog2(HEARTBEAT_DIV + 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_DIV - 1);

    logic [HB_W-1:0] hb_cnt_q;
    logic            hb_q;

    // Free-running toggle while in RUN; cleared whenever RUN is left.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (state_q != RUN) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else if (hb_cnt_q == HB_LAST) begin
            hb_cnt_q <= '0;
            hb_q     <= ~hb_q;
        end else begin
            hb_cnt_q <= hb_cnt_q + HB_W'(1);
        end
    end

    assign heartbeat_o = hb_q && (state_q == RUN);
`else
    assign heartbeat_o = 1'b0;
`endif

endmodule

// File: tb/tb_letc_fpga_rst_ctrl.sv
// Self-checking bench for letc_fpga_rst_ctrl (3 domains, short debounce).
// Directed scenarios plus random source/software activity vs a history model.
module tb_letc_fpga_rst_ctrl;

    localparam int NSRC = 2;
    localparam int NDOM = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int MAXE = 4096;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NSRC-1:0] src_rst_n_i;
    logic            sw_rst_req_i;
    logic [NDOM-1:0] dom_rst_n_o;
    logic            all_released_o;
    logic [NSRC+1:0] rst_cause_o;
    logic            heartbeat_o;

    always #5 clk = ~clk;

    letc_fpga_rst_ctrl #(
        .NUM_SRC         (NSRC),
        .NUM_DOM         (NDOM),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STAGE_GAP       (GAP),
        .HEARTBEAT_DIV   (2**24)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_rst_n_i    (src_rst_n_i),
        .sw_rst_req_i   (sw_rst_req_i),
        .dom_rst_n_o    (dom_rst_n_o),
        .all_released_o (all_released_o),
        .rst_cause_o    (rst_cause_o),
        .heartbeat_o    (heartbeat_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: edge count since rst_n release, run length of high pin
    // samples per source, length of the current run of reset-free edges.
    int         n;
    int         prun [NSRC][MAXE];
    int         clear_run;
    logic [3:0] m_cause;

    logic [NDOM-1:0] prev_dom;
    logic            prev_rel;
    int              rise [NDOM];
    int              rel_rise;
    int              fall_edge;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dom"}, 32'(dom_rst_n_o), 32'd0);
        chk({tag, "_rel"}, 32'(all_released_o), 32'd0);
        chk({tag, "_cause"}, 32'(rst_cause_o), 32'h1);
        chk({tag, "_hb"}, 32'(heartbeat_o), 32'd0);
    endtask

    task automatic model_init();
        n         = 0;
        clear_run = 0;
        m_cause   = 4'b0001;
        for (int i = 0; i < NSRC; i++) prun[i][0] = 0;
        prev_dom  = '0;
        prev_rel  = 1'b0;
        for (int k = 0; k < NDOM; k++) rise[k] = -1;
        rel_rise  = -1;
        fall_edge = -1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n        = 1'b0;
        src_rst_n_i  = '1;
        sw_rst_req_i = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk_reset_state("por");
        model_init();
        rst_n = 1'b1;
    endtask

    // One clock: drive, clock, advance the model, compare all outputs.
    task automatic cycle(input logic [NSRC-1:0] src, input logic sw);
        logic [NSRC-1:0] asrt;
        logic            any;
        logic [NDOM-1:0] exp_dom;
        logic            exp_rel;
        src_rst_n_i  = src;
        sw_rst_req_i = sw;
        @(posedge clk);
        n++;
        for (int i = 0; i < NSRC; i++) begin
            prun[i][n] = src[i] ? prun[i][n-1] + 1 : 0;
            // Clear only if the pin has been high DEB+1 samples, seen SYNC late.
            asrt[i] = (n <= SYNC) || (prun[i][n-SYNC] < DEB + 1);
        end
        any = (|asrt) || sw;
        if (any) begin
            if (clear_run > 0) m_cause = {sw, asrt, 1'b0};
            clear_run = 0;
        end else begin
            clear_run++;
        end
        for (int k = 0; k < NDOM; k++)
            exp_dom[k] = (clear_run >= HOLD + 1 + GAP * k);
        exp_rel = (clear_run >= HOLD + 1 + GAP * (NDOM - 1));
        #1;
        chk("dom", 32'(dom_rst_n_o), 32'(exp_dom));
        chk("all_rel", 32'(all_released_o), 32'(exp_rel));
        chk("cause", 32'(rst_cause_o), 32'(m_cause));
        chk("hb", 32'(heartbeat_o), 32'd0);
        for (int k = 0; k < NDOM; k++)
            if (dom_rst_n_o[k] && !prev_dom[k]) rise[k] = n;
        if (!dom_rst_n_o[0] && prev_dom[0]) fall_edge = n;
        if (all_released_o && !prev_rel) rel_rise = n;
        prev_dom = dom_rst_n_o;
        prev_rel = all_released_o;
    endtask

    initial begin
        int  e;
        logic d1_seen;

        // 1: power-on release timing
        do_reset(5);
        repeat (40) cycle(2'b11, 1'b0);
        chk("t1_dom0_rise", 32'(rise[0]), 32'd27);
        chk("t1_dom1_rise", 32'(rise[1]), 32'd31);
        chk("t1_dom2_rise", 32'(rise[2]), 32'd35);
        chk("t1_rel_rise", 32'(rel_rise), 32'd35);
        chk("t1_cause", 32'(rst_cause_o), 32'h1);

        // 2: a bounce on src0 restarts its debounce window
        do_reset(3);
        repeat (3) cycle(2'b11, 1'b0);
        cycle(2'b10, 1'b0);
        repeat (40) cycle(2'b11, 1'b0);
        chk("t2_dom0_rise", 32'(rise[0]), 32'd31);
        chk("t2_dom2_rise", 32'(rise[2]), 32'd39);

        // 3: one-cycle glitch on src1 while running
        e = n + 1;
        cycle(2'b01, 1'b0);
        repeat (40) cycle(2'b11, 1'b0);
        chk("t3_fall", 32'(fall_edge), 32'(e + 2));
        chk("t3_cause", 32'(rst_cause_o), 32'b0100);
        chk("t3_rerun", 32'(all_released_o), 32'd1);

        // 4: software request while running
        e = n + 1;
        cycle(2'b11, 1'b1);
        chk("t4_fall", 32'(fall_edge), 32'(e));
        chk("t4_cause", 32'(rst_cause_o), 32'b1000);
        repeat (30) cycle(2'b11, 1'b0);
        chk("t4_dom0_rise", 32'(rise[0]), 32'(e + 17));

        // 5: src0 glitch between dom0 and dom1 release
        cycle(2'b11, 1'b1);
        for (int i = 0; i < 100 && dom_rst_n_o != 3'b001; i++)
            cycle(2'b11, 1'b0);
        chk("t5_reach", 32'(dom_rst_n_o), 32'b001);
        e = n + 1;
        d1_seen = 1'b0;
        cycle(2'b10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(2'b11, 1'b0);
            d1_seen |= dom_rst_n_o[1] | dom_rst_n_o[2];
        end
        chk("t5_fall", 32'(fall_edge), 32'(e + 2));
        chk("t5_no_dom12", 32'(d1_seen), 32'd0);
        chk("t5_cause", 32'(rst_cause_o), 32'b0010);
        repeat (40) cycle(2'b11, 1'b0);

        // random source and software activity
        for (int i = 0; i < 2000; i++) begin
            logic [NSRC-1:0] s;
            for (int j = 0; j < NSRC; j++)
                s[j] = ($urandom_range(0, 149) != 0);
            cycle(s, ($urandom_range(0, 199) == 0));
        end
        repeat (60) cycle(2'b11, 1'b0);
        chk("rnd_run", 32'(all_released_o), 32'd1);

        // 6: asynchronous power-on reset mid-run
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
